// File: rtl/demux4_stream.sv
// demux4_stream
//   Steers one valid/ready input stream into four per-lane 2-entry FIFOs using
//   the 2-bit lane select that travels with each word. Each lane drains through
//   its own valid/ready output port and keeps a wrapping count of words it has
//   delivered.
//
// Ports
//   clk         single clock, all state on rising edge
//   rst         synchronous, active-high reset
//   in_valid    input word valid
//   in_ready    input word accepted when in_valid && in_ready
//   in_data     input word (W bits)
//   s           destination lane of in_data
//   out_valid   bit i: lane i holds at least one word
//   out_ready   bit i: lane i consumer takes the head word
//   out_data    lane i head word at [i*W +: W]
//   lane_count  lane i delivered-word count at [i*COUNT_W +: COUNT_W]

module demux4_stream #(
    parameter int W       = 4,
    parameter int COUNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_data,
    input  logic [1:0]           s,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [4*W-1:0]       out_data,
    output logic [4*COUNT_W-1:0] lane_count
);

    // Each lane is a two-slot shift FIFO: head_q is always the oldest word,
    // tail_q only holds data when occupancy is 2.
    logic [W-1:0]       head_q [4];
    logic [W-1:0]       head_d [4];
    logic [W-1:0]       tail_q [4];
    logic [W-1:0]       tail_d [4];
    logic [1:0]         occ_q  [4];
    logic [1:0]         occ_d  [4];
    logic [COUNT_W-1:0] cnt_q  [4];
    logic [COUNT_W-1:0] cnt_d  [4];

    logic [3:0] full;
    logic [3:0] push;
    logic [3:0] pop;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            full[i] = (occ_q[i] == 2'd2);
        end
    end

    // Backpressure looks only at the selected lane's registered occupancy, so
    // a full lane stalls the producer even if its consumer is popping now.
    assign in_ready = !full[s];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            push[i] = in_valid && in_ready && (s == 2'(i));
            pop[i]  = (occ_q[i] != 2'd0) && out_ready[i];
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            head_d[i] = head_q[i];
            tail_d[i] = tail_q[i];
            occ_d[i]  = occ_q[i];
            cnt_d[i]  = cnt_q[i];

            if (pop[i]) begin
                cnt_d[i] = cnt_q[i] + COUNT_W'(1);
            end

            case ({push[i], pop[i]})
                // Push and pop together only happens at occupancy 1: the new
                // word replaces the departing head.
                2'b11: head_d[i] = in_data;
                2'b10: begin
                    if (occ_q[i] == 2'd0) begin
                        head_d[i] = in_data;
                    end else begin
                        tail_d[i] = in_data;
                    end
                    occ_d[i] = occ_q[i] + 2'd1;
                end
                // Popping the last word leaves head_q untouched, so an empty
                // lane keeps showing its last value.
                2'b01: begin
                    if (occ_q[i] == 2'd2) begin
                        head_d[i] = tail_q[i];
                    end
                    occ_d[i] = occ_q[i] - 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                head_q[i] <= '0;
                tail_q[i] <= '0;
                occ_q[i]  <= 2'd0;
                cnt_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                head_q[i] <= head_d[i];
                tail_q[i] <= tail_d[i];
                occ_q[i]  <= occ_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            out_valid[i]                       = (occ_q[i] != 2'd0);
            out_data[i*W +: W]                 = head_q[i];
            lane_count[i*COUNT_W +: COUNT_W]   = cnt_q[i];
        end
    end

endmodule

// File: tb/tb_demux4_stream.sv
module tb_demux4_stream;

    localparam int W  = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [1:0]    s;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready;
    logic [4*W-1:0]  out_data;
    logic [4*CW-1:0] lane_count;

    demux4_stream #(.W(W), .COUNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .s          (s),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .lane_count (lane_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Scoreboard: per-lane queues of expected words plus model delivery counts.
    logic [W-1:0] mq [4][$];
    int           mcnt [4];
    bit           live = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model update at the active edge: push decision uses the model's own
    // occupancy before any pop of this cycle.
    always @(posedge clk) begin
        bit push_m;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                mq[i].delete();
                mcnt[i] = 0;
            end
            live = 1'b1;
        end else if (live) begin
            push_m = in_valid && (mq[s].size() != 2);
            for (int i = 0; i < 4; i++) begin
                if (mq[i].size() != 0 && out_ready[i]) begin
                    void'(mq[i].pop_front());
                    mcnt[i] = (mcnt[i] + 1) % (1 << CW);
                end
            end
            if (push_m) mq[s].push_back(in_data);
        end
    end

    // Continuous check on the falling edge.
    always @(negedge clk) begin
        if (live) begin
            chk("sb_in_ready", 32'(in_ready), 32'(mq[s].size() != 2));
            for (int i = 0; i < 4; i++) begin
                chk("sb_out_valid", 32'(out_valid[i]), 32'(mq[i].size() != 0));
                if (mq[i].size() != 0)
                    chk("sb_out_data", 32'(out_data[i*W +: W]), 32'(mq[i][0]));
                chk("sb_lane_count", 32'(lane_count[i*CW +: CW]), 32'(mcnt[i]));
            end
        end
    end

    typedef struct {
        logic       iv;
        logic [1:0] ss;
        logic [3:0] d;
        logic [3:0] ordy;
        logic       exp_ir;
        logic [3:0] exp_ov;
    } vec_t;

    vec_t vecs [11];

    task automatic drive(input logic iv, input logic [1:0] ss, input logic [3:0] d, input logic [3:0] ordy);
        in_valid  = iv;
        s         = ss;
        in_data   = d;
        out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // exp_ir / exp_ov describe the state seen while the row's inputs are applied.
        vecs[0]  = '{1'b1, 2'd2, 4'h5, 4'b0000, 1'b1, 4'b0000};
        vecs[1]  = '{1'b0, 2'd0, 4'h0, 4'b0100, 1'b1, 4'b0100};
        vecs[2]  = '{1'b1, 2'd1, 4'h1, 4'b0000, 1'b1, 4'b0000};
        vecs[3]  = '{1'b1, 2'd1, 4'h2, 4'b0000, 1'b1, 4'b0010};
        vecs[4]  = '{1'b1, 2'd1, 4'h3, 4'b0000, 1'b0, 4'b0010};
        vecs[5]  = '{1'b0, 2'd0, 4'h0, 4'b0000, 1'b1, 4'b0010};
        vecs[6]  = '{1'b1, 2'd1, 4'h3, 4'b0010, 1'b0, 4'b0010};
        vecs[7]  = '{1'b1, 2'd1, 4'h3, 4'b0000, 1'b1, 4'b0010};
        vecs[8]  = '{1'b0, 2'd0, 4'h0, 4'b0010, 1'b1, 4'b0010};
        vecs[9]  = '{1'b0, 2'd0, 4'h0, 4'b0010, 1'b1, 4'b0010};
        vecs[10] = '{1'b0, 2'd0, 4'h0, 4'b0000, 1'b1, 4'b0000};

        rst = 1'b1;
        drive(1'b0, 2'd0, 4'h0, 4'h0);
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_lane_count", lane_count, 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        tick();

        // Single word, fill/stall, drain of lane1.
        for (int r = 0; r < 11; r++) begin
            drive(vecs[r].iv, vecs[r].ss, vecs[r].d, vecs[r].ordy);
            @(negedge clk);
            chk($sformatf("vec%0d_in_ready", r), 32'(in_ready), 32'(vecs[r].exp_ir));
            chk($sformatf("vec%0d_out_valid", r), 32'(out_valid), 32'(vecs[r].exp_ov));
            tick();
        end
        drive(1'b0, 2'd0, 4'h0, 4'h0);
        @(negedge clk);
        chk("seq_lane_counts", lane_count, 32'h0001_0300);
        tick();

        // Steady stream across all lanes.
        for (int k = 0; k < 40; k++) begin
            drive(1'b1, 2'(k % 4), 4'(k * 7 + 3), 4'hF);
            @(negedge clk);
            chk("stream_in_ready", 32'(in_ready), 32'h1);
            tick();
        end
        drive(1'b0, 2'd0, 4'h0, 4'hF);
        tick();
        tick();

        // Simultaneous push and pop on lane3.
        drive(1'b1, 2'd3, 4'h7, 4'h0);
        tick();
        drive(1'b1, 2'd3, 4'hA, 4'b1000);
        @(negedge clk);
        chk("pp_head7", 32'(out_data[15:12]), 32'h7);
        tick();
        drive(1'b0, 2'd3, 4'h0, 4'h0);
        @(negedge clk);
        chk("pp_valid", 32'(out_valid[3]), 32'h1);
        chk("pp_headA", 32'(out_data[15:12]), 32'hA);
        chk("pp_not_full", 32'(in_ready), 32'h1);
        tick();
        drive(1'b0, 2'd0, 4'h0, 4'b1000);
        tick();
        drive(1'b0, 2'd0, 4'h0, 4'h0);
        @(negedge clk);
        chk("pp_empty", 32'(out_valid[3]), 32'h0);
        tick();

        // Mid-operation reset with partially full lanes.
        drive(1'b1, 2'd0, 4'h1, 4'h0);
        tick();
        drive(1'b1, 2'd1, 4'h2, 4'h0);
        tick();
        drive(1'b1, 2'd1, 4'h3, 4'h0);
        tick();
        drive(1'b1, 2'd2, 4'h4, 4'h0);
        tick();
        drive(1'b0, 2'd0, 4'h0, 4'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_out_valid", 32'(out_valid), 32'h0);
        chk("mrst_lane_count", lane_count, 32'h0);
        chk("mrst_out_data", 32'(out_data), 32'h0);
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 2'(k % 4), 4'h0, 4'hF);
            @(negedge clk);
            chk("mrst_stays_empty", 32'(out_valid), 32'h0);
            tick();
        end

        // Counter wrap on lane0: 257 deliveries.
        for (int k = 0; k < 257; k++) begin
            drive(1'b1, 2'd0, 4'(k), 4'b0001);
            tick();
        end
        drive(1'b0, 2'd0, 4'h0, 4'b0001);
        tick();
        tick();
        tick();
        @(negedge clk);
        chk("wrap_lane0", 32'(lane_count[7:0]), 32'h1);
        chk("wrap_others", 32'(lane_count[31:8]), 32'h0);
        chk("wrap_empty", 32'(out_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
